wavetable_rom_arbiter: RTL and testbench

WAVETABLE_ROM_ARBITER -- requirements
Module: wavetable_rom_arbiter

---
 rtl/wavetable_rom_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wavetable_rom_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_rom_arbiter.sv
// ---------------------------------------------------------------------------
// wavetable_rom_arbiter
// Shares one wavetable ROM read port between N_VOICES oscillators.
// - Round-robin arbiter with a combinational one-hot grant.
// - Registered ROM command (rom_en/rom_addr) one cycle after the grant.
// - A {valid, voice_id} shift pipeline of depth ROM_LATENCY+1 routes each
//   returning ROM word to its voice as a one-cycle rvalid pulse with rdata.
// Optional feature macro: WAVETABLE_ARB_HOLD_EN
//   Adds hold_data, a per-voice copy of the last response delivered to
//   that voice, held until the voice's next response.
// ---------------------------------------------------------------------------
`default_nettype none

module wavetable_rom_arbiter #(
   parameter int N_VOICES    = 8,
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 24,
   parameter int ROM_LATENCY = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic [N_VOICES-1:0]                   req,
   input  logic [N_VOICES-1:0][ADDR_WIDTH-1:0]   addr,
   output logic [N_VOICES-1:0]                   grant,
   output logic                                  rom_en,
   output logic [ADDR_WIDTH-1:0]                 rom_addr,
   input  logic [DATA_WIDTH-1:0]                 rom_data,
   output logic [N_VOICES-1:0]                   rvalid,
`ifdef WAVETABLE_ARB_HOLD_EN
   output logic [N_VOICES-1:0][DATA_WIDTH-1:0]   hold_data,
`endif
   output logic [DATA_WIDTH-1:0]                 rdata
);

   // Voice index width; a single voice still needs one bit.
   localparam int ID_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
   // Pipeline stage k describes the read whose rom_en was high k cycles ago;
   // the last stage lines up with valid rom_data.
   localparam int DEPTH = ROM_LATENCY + 1;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   // Modulo-N_VOICES addition for voice indices (N need not be a power of 2).
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int              offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= N_VOICES) sum = sum - N_VOICES;
      return ID_W'(sum);
   endfunction

   logic [ID_W-1:0]       r_rr_ptr;
   logic                  r_rom_en;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   tag_t                  r_pipe [DEPTH];
   logic [N_VOICES-1:0]   r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_any_grant;
   logic [ID_W-1:0]       w_grant_id;
   logic [N_VOICES-1:0]   w_grant;
   logic [ADDR_WIDTH-1:0] w_grant_addr;
   logic [N_VOICES-1:0]   w_resp_onehot;

   // Round-robin search starting at r_rr_ptr; first requester wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch; a path that leaves one unassigned would infer a latch.
      w_any_grant = 1'b0;
      w_grant_id  = '0;
      w_grant     = '0;
      if (!rst && enable) begin
         for (int k = 0; k < N_VOICES; k++) begin
            if (!w_any_grant && req[wrap_add(r_rr_ptr, k)]) begin
               w_any_grant = 1'b1;
               w_grant_id  = wrap_add(r_rr_ptr, k);
            end
         end
      end
      if (w_any_grant) w_grant[w_grant_id] = 1'b1;
   end

   assign w_grant_addr = addr[w_grant_id];
   assign grant        = w_grant;

   // Pointer advance and registered ROM read command.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         r_rr_ptr   <= '0;
         r_rom_en   <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_rom_en <= w_any_grant;
         if (w_any_grant) begin
            r_rom_addr <= w_grant_addr;
            r_rr_ptr   <= wrap_add(w_grant_id, 1);
         end
      end
   end

   assign rom_en   = r_rom_en;
   assign rom_addr = r_rom_addr;

   // Read-tracking pipeline: records who owns each ROM read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only the valid bits must clear to drop in-flight reads; the
         // ids are cleared too so no X ever reaches the response decoder.
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= '{valid: w_any_grant, id: w_grant_id};
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   // One-hot decode of the voice whose ROM word is on rom_data now.
   always_comb begin
      w_resp_onehot = '0;
      if (r_pipe[DEPTH-1].valid) w_resp_onehot[r_pipe[DEPTH-1].id] = 1'b1;
   end

   // Response register: rvalid pulses one cycle, rdata holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_resp_onehot;
         if (r_pipe[DEPTH-1].valid) r_rdata <= rom_data;
      end
   end

   assign rvalid = r_rvalid;
   assign rdata  = r_rdata;

`ifdef WAVETABLE_ARB_HOLD_EN
   logic [N_VOICES-1:0][DATA_WIDTH-1:0] r_hold;

   // Per-voice hold register, loaded alongside that voice's rvalid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= '0;
      end else begin
         for (int v = 0; v < N_VOICES; v++) begin
            if (w_resp_onehot[v]) r_hold[v] <= rom_data;
         end
      end
   end

   assign hold_data = r_hold;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wavetable_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wavetable_rom_arbiter
// Scoreboard bench: a reference model applies the round-robin rule with
// modulo arithmetic each cycle, checks grant and the ROM command, and
// queues the expected response (voice, address, due cycle). A separate
// monitor pops the queue whenever a response is presented or due.
// Define WAVETABLE_ARB_HOLD_EN to also check hold_data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wavetable_rom_arbiter;

   localparam int N  = 8;
   localparam int AW = 15;
   localparam int DW = 24;
   localparam int L  = 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  enable = 1'b0;
   logic [N-1:0]          req = '0;
   logic [N-1:0][AW-1:0]  addr = '0;
   logic [N-1:0]          grant;
   logic                  rom_en;
   logic [AW-1:0]         rom_addr;
   logic [DW-1:0]         rom_data;
   logic [N-1:0]          rvalid;
   logic [DW-1:0]         rdata;
`ifdef WAVETABLE_ARB_HOLD_EN
   logic [N-1:0][DW-1:0]  hold_data;
`endif

   wavetable_rom_arbiter #(
      .N_VOICES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(L)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .req(req), .addr(addr),
      .grant(grant), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .rvalid(rvalid),
`ifdef WAVETABLE_ARB_HOLD_EN
      .hold_data(hold_data),
`endif
      .rdata(rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ROM contents: an arbitrary fixed scramble of the address.
   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      logic [31:0] x;
      x = {17'd0, a} * 32'h9E37_79B1;
      return x[31:8] ^ {9'd0, a};
   endfunction

   // ROM with L cycles of latency; outside real reads it returns noise.
   logic [DW-1:0] rom_pipe [L];
   always @(posedge clk) begin
      rom_pipe[0] <= rom_en ? rom_fn(rom_addr) : DW'($urandom);
      for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[L-1];

   typedef struct {
      int           voice;
      logic [AW-1:0] a;
      int           due;
   } exp_t;

   exp_t sb[$];

   // Reference model state.
   int            m_rr = 0;
   logic          m_rom_en = 1'b0;
   logic [AW-1:0] m_rom_addr = '0;

   // Model: grant decision, ROM command check, response enqueue.
   always @(negedge clk) begin
      logic [N-1:0] eg;
      int           win;
      exp_t         keep[$];
      eg  = '0;
      win = -1;
      if (!rst && enable) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
         end
      end
      if (win >= 0) eg[win] = 1'b1;
      check("grant", 64'(grant), 64'(eg));
      check("rom_en", 64'(rom_en), 64'(m_rom_en));
      check("rom_addr", 64'(rom_addr), 64'(m_rom_addr));
      if (rst) begin
         m_rr       = 0;
         m_rom_en   = 1'b0;
         m_rom_addr = '0;
         keep.delete();
         foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
         sb = keep;
      end else if (win >= 0) begin
         sb.push_back('{voice: win, a: addr[win], due: cyc + 2 + L});
         m_rom_en   = 1'b1;
         m_rom_addr = addr[win];
         m_rr       = (win + 1) % N;
      end else begin
         m_rom_en = 1'b0;
      end
   end

`ifdef WAVETABLE_ARB_HOLD_EN
   logic [DW-1:0] m_hold [N] = '{default: '0};
`endif

   // Monitor: pops the scoreboard whenever a response is presented or due.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         check("rvalid_missing", 64'(rvalid), 64'(1) << sb[0].voice);
         void'(sb.pop_front());
      end
      if (rvalid != '0 || (sb.size() > 0 && sb[0].due == cyc)) begin
         if (sb.size() == 0) begin
            check("rvalid_unexpected", 64'(rvalid), 64'(0));
         end else begin
            e = sb.pop_front();
            check("rvalid_voice", 64'(rvalid), 64'(1) << e.voice);
            check("rvalid_cycle", 64'(cyc), 64'(e.due));
            check("rdata", 64'(rdata), 64'(rom_fn(e.a)));
`ifdef WAVETABLE_ARB_HOLD_EN
            m_hold[e.voice] = rom_fn(e.a);
`endif
         end
      end
`ifdef WAVETABLE_ARB_HOLD_EN
      for (int v = 0; v < N; v++) check($sformatf("hold_data[%0d]", v), 64'(hold_data[v]), 64'(m_hold[v]));
      if (rst) for (int v = 0; v < N; v++) m_hold[v] = '0;
`endif
   end

   // Apply inputs for the current cycle, then advance to just after the edge.
   task automatic cyc_drive(input logic r, input logic e, input logic [N-1:0] q);
      rst    = r;
      enable = e;
      req    = q;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b1, '0);
   endtask

   initial begin
      // Reset
      for (int i = 0; i < 3; i++) cyc_drive(1'b1, 1'b0, '0);
      check("reset_rvalid", 64'(rvalid), 64'(0));
      check("reset_rdata", 64'(rdata), 64'(0));
      check("reset_rom_en", 64'(rom_en), 64'(0));

      // Single request: voice 2 at 0x123
      addr[2] = 15'h123;
      cyc_drive(1'b0, 1'b1, 8'h04);
      idle(5);

      // Full load: all voices request continuously
      for (int v = 0; v < N; v++) addr[v] = AW'($urandom);
      for (int i = 0; i < 20; i++) cyc_drive(1'b0, 1'b1, 8'hFF);
      idle(5);

      // Rotation: bring pointer to 4, then voices 3 and 5 compete
      cyc_drive(1'b0, 1'b1, 8'h08);
      cyc_drive(1'b0, 1'b1, 8'h28);
      cyc_drive(1'b0, 1'b1, 8'h08);
      idle(5);

      // Reset while a read for voice 6 is in flight
      addr[6] = AW'($urandom);
      cyc_drive(1'b0, 1'b1, 8'h40);
      cyc_drive(1'b1, 1'b1, 8'h00);
      idle(6);

      // Enable gating: voice 1 granted, then voice 4 waits while disabled
      addr[1] = AW'($urandom);
      addr[4] = AW'($urandom);
      cyc_drive(1'b0, 1'b1, 8'h02);
      for (int i = 0; i < 4; i++) cyc_drive(1'b0, 1'b0, 8'h10);
      cyc_drive(1'b0, 1'b1, 8'h10);
      idle(5);

      // Voice 1 then voice 2 back to back
      addr[1] = 15'h010;
      cyc_drive(1'b0, 1'b1, 8'h02);
      addr[2] = AW'($urandom);
      cyc_drive(1'b0, 1'b1, 8'h04);
      idle(6);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         for (int v = 0; v < N; v++) addr[v] = AW'($urandom);
         cyc_drive($urandom_range(0, 99) < 2,
                   $urandom_range(0, 9) != 0,
                   ($urandom_range(0, 3) == 0) ? N'($urandom) : (N'($urandom) & N'($urandom)));
      end

      // Drain with a bounded wait
      for (int i = 0; i < 50 && sb.size() > 0; i++) cyc_drive(1'b0, 1'b0, '0);
      check("drain_pending", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
